proc_param: RTL and testbench
=============================

PROC_PARAM -- requirements
Module: proc_param

Interface
REQ-001 Parameter W, default 9: data, address and instruction width; SHALL be >= 9.
REQ-002 Parameter PC_RESET, default 0: value loaded into PC (R7) on reset.
REQ-003 Clock  input  1  rising-edge clock for all state.
REQ-004 Resetn  input  1  asynchronous, active-low reset.
REQ-005 Run  input  1  start fetch of next instruction; sampled only in IDLE.
REQ-006 DIN  input  W  read data from the memory/IO device; valid in the cycle Req&Ready is high.
REQ-007 Ready  input  1  device completes the current access at the edge where Req&Ready=1.
REQ-008 ADDR  output  W  registered access address.
REQ-009 DOUT  output  W  registered store data.
REQ-010 Write  output  1  registered; 1 = current access is a store.
REQ-011 Req  output  1  registered access request; held with ADDR/DOUT/Write stable until completion.
REQ-012 Done  output  1  high only for the cycle whose ending edge commits an instruction.
REQ-013 Zf, Cf  output  1 each  registered zero and carry flags.

Function
REQ-014 Instruction fields: opcode IR[W-1:W-3], X IR[W-4:W-6], Y IR[W-7:W-9]; bits below W-9 ignored.
REQ-015 Opcodes: 000 mv, 001 mvi, 010 add, 011 sub, 100 ld, 101 st, 110 mvnz, 111 and.
REQ-016 Registers R0-R6 W bits; R7 is PC; register index 7 reads/writes PC.
REQ-017 States: IDLE, FETCH, EXEC, MEM, WB; no other reachable states.
REQ-018 IDLE: if Run, ADDR<=PC, Write<=0, Req<=1, go FETCH; else stay.
REQ-019 FETCH: on Req&Ready, IR<=DIN, PC<=PC+1 (mod 2^W), Req<=0, go EXEC.
REQ-020 EXEC mv: Rx<=Ry, Done, go IDLE; mvnz: same but write only if Zf=0.
REQ-021 EXEC mvi: ADDR<=PC, Req<=1, go MEM; on completion Rx<=DIN, PC<=PC+1, Done; if X=7, DIN wins over increment.
REQ-022 EXEC ld: ADDR<=Ry, Req<=1, go MEM; on completion Rx<=DIN, Done.
REQ-023 EXEC st: ADDR<=Ry, DOUT<=Rx, Write<=1, Req<=1, go MEM; on completion Write<=0, Done, no register write.
REQ-024 MEM: Req<=0 at completion, go IDLE; while Ready=0 all outputs hold.
REQ-025 EXEC add/sub/and: G<=Rx op Ry (W bits), Zf<=(result==0), go WB; WB: Rx<=G, Done, go IDLE.
REQ-026 Cf: add = carry out of bit W-1; sub = borrow (Rx<Ry unsigned); and = 0; other opcodes leave Zf/Cf unchanged.
REQ-027 Explicit write to R7 overrides increment in the same cycle.
REQ-028 Latency with zero wait: mv/mvnz 3 cycles, add/sub/and 4, mvi/ld/st 4; each wait cycle adds 1.
REQ-029 Run deasserted mid-instruction SHALL NOT abort it.

Reset
REQ-030 Resetn=0 immediately forces state IDLE, Req=0, Write=0, Done=0, ADDR=0, DOUT=0, Zf=0, Cf=0, R0-R6=0, IR=0, G=0, PC=PC_RESET.
REQ-031 Reset during a pending access abandons it; no register or flag update occurs.

Configuration
REQ-032 Macro PROC_WAIT_EN defined: Ready honoured as above.
REQ-033 PROC_WAIT_EN undefined: Ready ignored, treated as 1; every access completes one cycle after Req rises; port still present.

Verification
REQ-034 W=9, Ready=1, mem[0]=mvi R0, mem[1]=5, Run pulse -> R0=5, PC=2, Done 4th cycle, two Req pulses.
REQ-035 R1=0x1FF, R2=1, add R1,R2 -> R1=0, Zf=1, Cf=1; then sub R1,R2 -> R1=0x1FF, Zf=0, Cf=1.
REQ-036 Zf=1, mvnz R3,R4 (R4=7) -> R3 unchanged; after Zf=0 repeat -> R3=7.
REQ-037 PROC_WAIT_EN, st R5->[R6=0x20], Ready low 3 cycles -> Req high 4 cycles, ADDR=0x20, DOUT=R5, Write=1 stable, one Done.
REQ-038 Resetn low during ld wait -> Req=0, Write=0 same cycle, PC=PC_RESET, target register unchanged.
REQ-039 W=16, mv R7,R3 with R3=0x1234 -> next fetch ADDR=0x1234.

Source files
------------

// File: rtl/proc_param_if.sv
// proc_param_if: memory/IO bus between the proc_param core and its device.
// master = core (ADDR, DOUT, Write, Req out; DIN, Ready in); slave = device.
interface proc_param_if #(
  parameter int W = 9
);
  logic [W-1:0] ADDR;
  logic [W-1:0] DOUT;
  logic [W-1:0] DIN;
  logic         Write;
  logic         Req;
  logic         Ready;

  modport master (
    output ADDR, DOUT, Write, Req,
    input  DIN, Ready
  );

  modport slave (
    input  ADDR, DOUT, Write, Req,
    output DIN, Ready
  );
endinterface

// File: rtl/proc_param.sv
// proc_param: multicycle 8-opcode processor, R0-R6 plus R7 as PC.
// Ports: Clock, Resetn (async, low), Run, Done, Zf, Cf, bus (master).
// Macro PROC_WAIT_EN: honour bus.Ready; otherwise every access
// completes one cycle after Req rises.
module proc_param #(
  parameter int          W        = 9,
  parameter logic [W-1:0] PC_RESET = '0
) (
  input  logic Clock,
  input  logic Resetn,
  input  logic Run,
  output logic Done,
  output logic Zf,
  output logic Cf,
  proc_param_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXEC,
    MEM,
    WB
  } state_t;

  localparam logic [W-1:0] ONE = 1;

  state_t       state;
  logic [W-1:0] ir;
  logic [W-1:0] g;
  logic [W-1:0] regs [8];

  logic [2:0] op;
  logic [2:0] x;
  logic [2:0] y;

  assign op = ir[W-1:W-3];
  assign x  = ir[W-4:W-6];
  assign y  = ir[W-7:W-9];

  logic is_mv, is_mvi, is_add, is_sub;
  logic is_ld, is_st, is_mvnz, is_and;

  assign is_mv   = (op == 3'b000);
  assign is_mvi  = (op == 3'b001);
  assign is_add  = (op == 3'b010);
  assign is_sub  = (op == 3'b011);
  assign is_ld   = (op == 3'b100);
  assign is_st   = (op == 3'b101);
  assign is_mvnz = (op == 3'b110);
  assign is_and  = (op == 3'b111);

  logic [W-1:0] rx;
  logic [W-1:0] ry;

  // Index 7 is the PC, so R7 reads need no special case.
  assign rx = regs[x];
  assign ry = regs[y];

  logic rdy;
  logic acc;

`ifdef PROC_WAIT_EN
  assign rdy = bus.Ready;
`else
  // Port kept for compatibility; its value has no effect.
  assign rdy = bus.Ready | 1'b1;
`endif

  assign acc = bus.Req & rdy;

  logic [W:0]   sum;
  logic [W:0]   dif;
  logic [W-1:0] res;
  logic         cout;

  assign sum = {1'b0, rx} + {1'b0, ry};
  assign dif = {1'b0, rx} - {1'b0, ry};

  always_comb begin
    res  = '0;
    cout = 1'b0;
    unique case (1'b1)
      is_add: begin
        res  = sum[W-1:0];
        cout = sum[W];
      end
      is_sub: begin
        res  = dif[W-1:0];
        cout = dif[W];
      end
      is_and: begin
        res  = rx & ry;
        cout = 1'b0;
      end
      default: ;
    endcase
  end

  logic         wr_en;
  logic [W-1:0] wr_val;

  always_comb begin
    wr_en  = 1'b0;
    wr_val = g;
    unique case (state)
      EXEC: begin
        wr_en  = is_mv | (is_mvnz & ~Zf);
        wr_val = ry;
      end
      MEM: begin
        wr_en  = acc & ~is_st;
        wr_val = bus.DIN;
      end
      WB: begin
        wr_en  = 1'b1;
        wr_val = g;
      end
      default: ;
    endcase
  end

  assign Done = ((state == EXEC) & (is_mv | is_mvnz))
              | ((state == MEM) & acc)
              | (state == WB);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state     <= IDLE;
      ir        <= '0;
      g         <= '0;
      Zf        <= 1'b0;
      Cf        <= 1'b0;
      bus.ADDR  <= '0;
      bus.DOUT  <= '0;
      bus.Write <= 1'b0;
      bus.Req   <= 1'b0;
      for (int i = 0; i < 7; i++) begin
        regs[i] <= '0;
      end
      regs[7] <= PC_RESET;
    end else begin
      unique case (state)
        IDLE: begin
          if (Run) begin
            bus.ADDR  <= regs[7];
            bus.Write <= 1'b0;
            bus.Req   <= 1'b1;
            state     <= FETCH;
          end
        end
        FETCH: begin
          if (acc) begin
            ir      <= bus.DIN;
            regs[7] <= regs[7] + ONE;
            bus.Req <= 1'b0;
            state   <= EXEC;
          end
        end
        EXEC: begin
          unique case (1'b1)
            is_mv, is_mvnz: begin
              state <= IDLE;
            end
            is_mvi: begin
              bus.ADDR <= regs[7];
              bus.Req  <= 1'b1;
              state    <= MEM;
            end
            is_ld: begin
              bus.ADDR <= ry;
              bus.Req  <= 1'b1;
              state    <= MEM;
            end
            is_st: begin
              bus.ADDR  <= ry;
              bus.DOUT  <= rx;
              bus.Write <= 1'b1;
              bus.Req   <= 1'b1;
              state     <= MEM;
            end
            default: begin
              g     <= res;
              Zf    <= (res == '0);
              Cf    <= cout;
              state <= WB;
            end
          endcase
        end
        MEM: begin
          if (acc) begin
            bus.Req   <= 1'b0;
            bus.Write <= 1'b0;
            if (is_mvi) begin
              regs[7] <= regs[7] + ONE;
            end
            state <= IDLE;
          end
        end
        WB: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
      // Placed last so an explicit R7 write beats the PC increment.
      if (wr_en) begin
        regs[x] <= wr_val;
      end
    end
  end

endmodule

// File: tb/tb_proc_param.sv
// tb_proc_param: instruction-level model + bus scoreboard for proc_param.
// Also exercises a W=16 instance for a jump through mv R7.
module tb_proc_param;
  localparam int W = 9;
`ifdef PROC_WAIT_EN
  localparam bit WAITS = 1'b1;
`else
  localparam bit WAITS = 1'b0;
`endif

  logic Clock  = 1'b0;
  logic Resetn = 1'b0;
  logic Run    = 1'b0;
  logic Run16  = 1'b0;
  logic Done, Zf, Cf;
  logic Done16, Zf16, Cf16;

  proc_param_if #(.W(W))  bus ();
  proc_param_if #(.W(16)) bus16 ();

  proc_param #(.W(W), .PC_RESET(9'd0)) dut (
    .Clock (Clock),
    .Resetn(Resetn),
    .Run   (Run),
    .Done  (Done),
    .Zf    (Zf),
    .Cf    (Cf),
    .bus   (bus.master)
  );

  proc_param #(.W(16), .PC_RESET(16'd0)) dut16 (
    .Clock (Clock),
    .Resetn(Resetn),
    .Run   (Run16),
    .Done  (Done16),
    .Zf    (Zf16),
    .Cf    (Cf16),
    .bus   (bus16.master)
  );

  always #5 Clock = ~Clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(string nm, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] enc(int op, int x, int y);
    logic [W-1:0] v;
    v = {op[2:0], x[2:0], y[2:0]};
    return v;
  endfunction

  function automatic int stall_of(int i);
    case (i)
      5:       return 1;
      9:       return 2;
      12:      return 1;
      17:      return 3;
      22:      return 1;
      25:      return 2;
      default: return 0;
    endcase
  endfunction

  function automatic logic [15:0] rom16(logic [15:0] a);
    case (a)
      16'h0000: return 16'h2C00;
      16'h0001: return 16'h1234;
      16'h0002: return 16'h1D80;
      default:  return 16'h0000;
    endcase
  endfunction

  // Device memory and responder
  logic [W-1:0] mem [512];
  assign bus.DIN     = mem[bus.ADDR];
  assign bus16.DIN   = rom16(bus16.ADDR);
  assign bus16.Ready = 1'b1;

  int r_acc = 0;
  int r_cnt = 0;
  bit r_busy = 1'b0;

  always @(posedge Clock) begin
    if (!Resetn) begin
      r_busy    = 1'b0;
      r_cnt     = 0;
      r_acc     = 0;
      bus.Ready = 1'b1;
    end else begin
      if (bus.Req && (bus.Ready || !WAITS)) begin
        if (bus.Write) mem[bus.ADDR] = bus.DOUT;
        r_acc++;
        r_busy = 1'b0;
        r_cnt  = 0;
      end
      #1;
      if (bus.Req && !r_busy) begin
        r_busy = 1'b1;
        r_cnt  = stall_of(r_acc);
      end
      bus.Ready = (r_cnt == 0);
      if (r_cnt > 0) r_cnt--;
    end
  end

  // Instruction-level model
  logic [W-1:0] mmem [512];
  logic [W-1:0] mr [8];
  logic [W-1:0] mir, mdata, e_addr, e_dout, h_addr, h_dout;
  bit mz, mc, e_wr, h_wr, in_acc;
  int ph, lat, lat_exp, m_acc, h_len;
  int done_n = 0;
  int st_n   = 0;
  int mop, mx, my, a, b, s, rr;

  always @(negedge Clock) begin
    if (!Resetn) begin
      for (int i = 0; i < 8; i++) mr[i] = '0;
      mz = 0; mc = 0; ph = 0; lat = 0; lat_exp = 0;
      m_acc = 0; in_acc = 0; h_len = 0;
    end else begin
      if (Run || lat > 0 || ph != 0) lat++;
      mop = int'(mir[8:6]);
      mx  = int'(mir[5:3]);
      my  = int'(mir[2:0]);
      if (bus.Req && ph == 2) chk("req_in_commit", bus.Req, 0);
      if (bus.Req && ph != 2) begin
        if (!in_acc) begin
          e_wr = 0; e_dout = '0; e_addr = mr[7];
          if (ph == 1 && mop == 4) e_addr = mr[my];
          if (ph == 1 && mop == 5) begin
            e_addr = mr[my]; e_wr = 1; e_dout = mr[mx];
          end
          chk("acc_addr", bus.ADDR, e_addr);
          chk("acc_write", bus.Write, e_wr);
          if (e_wr) chk("acc_dout", bus.DOUT, e_dout);
          h_addr = bus.ADDR; h_dout = bus.DOUT; h_wr = bus.Write;
          in_acc = 1; h_len = 0;
        end else begin
          chk("hold_addr", bus.ADDR, h_addr);
          chk("hold_write", bus.Write, h_wr);
          if (h_wr) chk("hold_dout", bus.DOUT, h_dout);
        end
        h_len++;
        if (bus.Ready || !WAITS) begin
          chk("acc_len", h_len, WAITS ? stall_of(m_acc) + 1 : 1);
          lat_exp += WAITS ? stall_of(m_acc) : 0;
          m_acc++;
          in_acc = 0;
          if (ph == 0) begin
            mir = mmem[mr[7]];
            mr[7] = mr[7] + 1;
            mop = int'(mir[8:6]);
            ph = (mop == 1 || mop == 4 || mop == 5) ? 1 : 2;
          end else begin
            if (mop == 1) begin
              mdata = mmem[mr[7]];
              mr[7] = mr[7] + 1;
            end else if (mop == 4) begin
              mdata = mmem[mr[my]];
            end else begin
              mmem[mr[my]] = mr[mx];
              case (st_n)
                0: chk("st0_dout", bus.DOUT, 9'h003);
                1: chk("st1_dout", bus.DOUT, 9'h007);
                2: chk("st2_dout", bus.DOUT, 9'h0B2);
                3: chk("st3_dout", bus.DOUT, 9'h007);
                default: ;
              endcase
              st_n++;
            end
            ph = 2;
          end
        end
      end
      if (Done) begin
        chk("done_phase", ph, 2);
        a = int'(mr[mx]);
        b = int'(mr[my]);
        case (mop)
          0: mr[mx] = mr[my];
          6: if (!mz) mr[mx] = mr[my];
          1, 4: mr[mx] = mdata;
          2, 3, 7: begin
            if (mop == 2) begin
              s = a + b; rr = s % 512; mc = (s > 511);
            end else if (mop == 3) begin
              rr = (a - b + 512) % 512; mc = (a < b);
            end else begin
              rr = a & b; mc = 0;
            end
            mz = (rr == 0);
            mr[mx] = W'(rr);
          end
          default: ;
        endcase
        chk("latency", lat, ((mop == 0 || mop == 6) ? 3 : 4) + lat_exp);
        chk("Zf", Zf, mz);
        chk("Cf", Cf, mc);
        case (done_n)
          0: begin
            chk("first_latency", lat, 4);
            chk("first_req_pulses", m_acc, 2);
          end
          3: begin
            chk("add_Zf", Zf, 1);
            chk("add_Cf", Cf, 1);
          end
          4: begin
            chk("sub_Zf", Zf, 0);
            chk("sub_Cf", Cf, 1);
          end
          7: begin
            chk("subz_Zf", Zf, 1);
            chk("subz_Cf", Cf, 0);
          end
          default: ;
        endcase
        done_n++;
        ph = 0; lat = 0; lat_exp = 0;
      end
    end
  end

  logic [15:0] a16 [$];
  always @(negedge Clock) begin
    if (Resetn && bus16.Req) a16.push_back(bus16.ADDR);
  end

  task automatic wait_done(int n, int budget);
    int k = 0;
    while (done_n < n && k < budget) begin
      @(posedge Clock);
      #2;
      k++;
    end
    chk("done_count", done_n, n);
  endtask

  initial begin
    logic [W-1:0] p [512];
    int k;
    int dn;
    for (int i = 0; i < 512; i++) p[i] = '0;
    p[0]  = enc(1, 0, 0); p[1]  = 9'd5;
    p[2]  = enc(1, 1, 0); p[3]  = 9'h1FF;
    p[4]  = enc(1, 2, 0); p[5]  = 9'd1;
    p[6]  = enc(2, 1, 2); p[7]  = enc(3, 1, 2);
    p[8]  = enc(1, 4, 0); p[9]  = 9'd7;
    p[10] = enc(1, 3, 0); p[11] = 9'd3;
    p[12] = enc(3, 2, 2); p[13] = enc(6, 3, 4);
    p[14] = enc(1, 6, 0); p[15] = 9'h020;
    p[16] = enc(5, 3, 6); p[17] = enc(7, 4, 4);
    p[18] = enc(6, 3, 4);
    p[19] = enc(1, 5, 0); p[20] = 9'h0AB;
    p[21] = enc(5, 3, 6); p[22] = enc(4, 1, 6);
    p[23] = enc(0, 2, 1); p[24] = enc(2, 5, 2);
    p[25] = enc(1, 6, 0); p[26] = 9'h021;
    p[27] = enc(5, 5, 6);
    p[28] = enc(1, 7, 0); p[29] = 9'd40;
    p[40] = enc(1, 6, 0); p[41] = 9'h022;
    p[42] = enc(5, 1, 6); p[43] = enc(4, 5, 6);
    for (int i = 0; i < 512; i++) begin
      mem[i]  = p[i];
      mmem[i] = p[i];
    end

    repeat (2) @(posedge Clock);
    #1;
    chk("rst_req", bus.Req, 0);
    chk("rst_write", bus.Write, 0);
    chk("rst_done", Done, 0);
    chk("rst_addr", bus.ADDR, 0);
    chk("rst_dout", bus.DOUT, 0);
    chk("rst_zf", Zf, 0);
    chk("rst_cf", Cf, 0);
    #1;
    Resetn = 1'b1;
    repeat (2) @(posedge Clock);
    #1;
    chk("idle_no_run", bus.Req, 0);

    #1;
    Run = 1'b1;
    wait_done(23, 600);
    Run = 1'b0;
    repeat (5) @(negedge Clock);
    chk("idle_hold_req", bus.Req, 0);
    chk("mem_20", mem[9'h020], 9'h007);
    chk("mem_21", mem[9'h021], 9'h0B2);
    chk("mem_22", mem[9'h022], 9'h007);

    // Reset while the ld at 43 has its data access pending
    @(posedge Clock);
    #2;
    Run = 1'b1;
    k = 0;
    do begin
      @(negedge Clock);
      k++;
    end while (!(bus.Req && !bus.Write && bus.ADDR == 9'h022) && k < 30);
    chk("ld_access_seen", bus.ADDR, 9'h022);
    #2;
    Resetn = 1'b0;
    Run    = 1'b0;
    #1;
    chk("arst_req", bus.Req, 0);
    chk("arst_write", bus.Write, 0);
    chk("arst_addr", bus.ADDR, 0);
    chk("arst_done", Done, 0);
    repeat (2) @(posedge Clock);
    #2;
    Resetn = 1'b1;

    // Single Run pulse restarts from PC_RESET and runs one instruction
    dn = done_n;
    @(posedge Clock);
    #2;
    Run = 1'b1;
    @(posedge Clock);
    #2;
    Run = 1'b0;
    k = 0;
    do begin
      @(negedge Clock);
      k++;
    end while (!bus.Req && k < 20);
    chk("pc_after_reset", bus.ADDR, 0);
    wait_done(dn + 1, 30);
    repeat (4) @(negedge Clock);
    chk("run_pulse_once", bus.Req, 0);

    // W=16: mvi R3,0x1234 ; mv R7,R3 -> next fetch from 0x1234
    @(posedge Clock);
    #2;
    Run16 = 1'b1;
    k = 0;
    while (a16.size() < 4 && k < 40) begin
      @(posedge Clock);
      k++;
    end
    Run16 = 1'b0;
    chk("w16_accesses", (a16.size() >= 4) ? 4 : a16.size(), 4);
    if (a16.size() >= 4) begin
      chk("w16_fetch0", a16[0], 16'h0000);
      chk("w16_data1", a16[1], 16'h0001);
      chk("w16_fetch2", a16[2], 16'h0002);
      chk("w16_jump", a16[3], 16'h1234);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
